pixel_uart_tx: RTL and testbench

- Downstream consumer of the pixel state machine's AXI-Stream output: 8-bit pixel bytes with valid/ready/tlast.
- Serialises each frame onto a single UART line (8N1 by default, LSB first) for off-chip readout.
- Inserts a header byte before the first pixel of every frame.
- Reports frame completion and the byte count of the last completed frame.

---
 rtl/pixel_uart_pkg.sv | 21 ++
 rtl/uart_tx_core.sv | 99 +++++++++
 rtl/pixel_uart_tx.sv | 115 +++++++++++
 tb/tb_pixel_uart_tx.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_uart_pkg.sv
// Shared types and defaults for the pixel-stream UART transmitter.
package pixel_uart_pkg;

    localparam int         DATA_W          = 8;
    localparam int         DEFAULT_CLK_DIV = 16;
    localparam logic [7:0] DEFAULT_HEADER  = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PIX  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_START = 2'd1,
        C_DATA  = 2'd2,
        C_STOP  = 2'd3
    } core_state_t;

endpackage

// File: rtl/uart_tx_core.sv
// Byte serialiser: start bit, 8 data bits LSB first, STOP_BITS stop bits.
module uart_tx_core
    import pixel_uart_pkg::*;
#(
    parameter int CLK_DIV   = DEFAULT_CLK_DIV,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic              tx,
    output logic              idle,
    output logic              done
);

    localparam int                BAUD_W    = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    core_state_t       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_d;
    logic              bit_end;

    assign idle = (state_q == C_IDLE);

    // tx is registered from the current state, so the line lags the core by one cycle
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        done    = 1'b0;
        bit_end = (baud_q == BAUD_LAST);
        baud_d  = bit_end ? '0 : baud_q + BAUD_W'(1);
        case (state_q)
            C_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (load) begin
                    state_d = C_START;
                    shift_d = data;
                end
            end
            C_START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    state_d = C_DATA;
                    bit_d   = '0;
                end
            end
            C_DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = C_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            C_STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = C_IDLE;
                        done    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: state_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= C_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            tx      <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx      <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

endmodule

// File: rtl/pixel_uart_tx.sv
// AXI-Stream pixel bytes to UART: header byte per frame, frame byte count and done pulse.
module pixel_uart_tx
    import pixel_uart_pkg::*;
#(
    parameter int                CLK_DIV   = DEFAULT_CLK_DIV,
    parameter int                STOP_BITS = 1,
    parameter logic [DATA_W-1:0] HEADER    = DEFAULT_HEADER,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_tlast,
    input  logic [DATA_W-1:0] s_data,
    output logic              tx,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_bytes
);

    state_t            state_q, state_d;
    logic              sof_q, sof_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  frame_bytes_d;
    logic              frame_done_d;
    logic              load;
    logic [DATA_W-1:0] load_data;
    logic              core_idle;
    logic              core_done;
    logic              accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign s_ready = (state_q == IDLE) && core_idle && !sof_q && !reset;
    assign accept  = s_valid && s_ready;
    assign busy    = (state_q != IDLE);

    // Header load never consumes the pending pixel; it is taken in the next IDLE cycle
    always_comb begin
        state_d       = state_q;
        sof_d         = sof_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        frame_bytes_d = frame_bytes;
        frame_done_d  = 1'b0;
        load          = 1'b0;
        load_data     = HEADER;
        case (state_q)
            IDLE: begin
                if (s_valid && core_idle && sof_q) begin
                    load    = 1'b1;
                    sof_d   = 1'b0;
                    state_d = HDR;
                end else if (accept) begin
                    load      = 1'b1;
                    load_data = s_data;
                    last_d    = s_tlast;
                    cnt_d     = sat_inc(cnt_q);
                    state_d   = PIX;
                end
            end
            HDR: begin
                if (core_done) state_d = IDLE;
            end
            PIX: begin
                if (core_done) begin
                    state_d = IDLE;
                    if (last_q) begin
                        frame_done_d  = 1'b1;
                        frame_bytes_d = cnt_q;
                        cnt_d         = '0;
                        sof_d         = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sof_q       <= 1'b1;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            frame_bytes <= '0;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sof_q       <= sof_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            frame_bytes <= frame_bytes_d;
            frame_done  <= frame_done_d;
        end
    end

    uart_tx_core #(
        .CLK_DIV  (CLK_DIV),
        .STOP_BITS(STOP_BITS)
    ) u_core (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .data (load_data),
        .tx   (tx),
        .idle (core_idle),
        .done (core_done)
    );

endmodule

// File: tb/tb_pixel_uart_tx.sv
// Bench for pixel_uart_tx: UART decoder and frame scoreboard against two configurations.
module tb_pixel_uart_tx;

    localparam int DIV0  = 4;
    localparam int STOP0 = 1;
    localparam int DIV1  = 3;
    localparam int STOP1 = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] s_valid, s_tlast, s_ready, tx, busy, frame_done;
    logic [7:0] s_data [2];
    logic [15:0] fb0;
    logic [1:0]  fb1;

    int n_tests = 0;
    int n_fail  = 0;
    int fd_cnt [2];
    int hs_cnt [2];
    int n_sent [2];
    int viol      = 0;
    int rst_epoch = 0;
    int frame_err = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int fb_q0[$];
    int exp_fb0[$];

    always #5 clk = ~clk;

    pixel_uart_tx #(.CLK_DIV(DIV0), .STOP_BITS(STOP0), .HEADER(8'hA5), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .s_tlast(s_tlast[0]), .s_data(s_data[0]), .tx(tx[0]), .busy(busy[0]),
        .frame_done(frame_done[0]), .frame_bytes(fb0));

    pixel_uart_tx #(.CLK_DIV(DIV1), .STOP_BITS(STOP1), .HEADER(8'hA5), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .s_tlast(s_tlast[1]), .s_data(s_data[1]), .tx(tx[1]), .busy(busy[1]),
        .frame_done(frame_done[1]), .frame_bytes(fb1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level k cycles after the handshake edge of a byte
    function automatic logic exp_tx(input int k, input int div, input logic [7:0] d);
        if (k < 1 || k > 9 * div) return 1'b1;
        if (k <= div) return 1'b0;
        return d[(k - 1 - div) / div];
    endfunction

    // Per-cycle monitors: frame_done log, handshake count, ready-while-busy, reset epochs
    initial begin
        fd_cnt = '{0, 0};
        hs_cnt = '{0, 0};
        forever begin
            @(negedge clk);
            if (reset === 1'b1) rst_epoch++;
            for (int i = 0; i < 2; i++) begin
                if (reset !== 1'b1 && frame_done[i] === 1'b1) begin
                    fd_cnt[i]++;
                    if (i == 0) fb_q0.push_back(int'(fb0));
                end
                if (reset !== 1'b1 && s_valid[i] === 1'b1 && s_ready[i] === 1'b1) hs_cnt[i]++;
                if (busy[i] === 1'b1 && s_ready[i] === 1'b1) viol++;
            end
        end
    end

    // UART receiver on dut0: mid-bit sampling, bytes cut by reset are discarded
    initial begin
        int ep;
        logic [7:0] b;
        logic ok;
        forever begin
            do @(negedge clk); while (!(tx[0] === 1'b0 && reset !== 1'b1));
            ep = rst_epoch;
            ok = 1'b1;
            repeat (DIV0 / 2) @(negedge clk);
            if (tx[0] !== 1'b0) ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
                repeat (DIV0) @(negedge clk);
                b[i] = tx[0];
            end
            repeat (DIV0) @(negedge clk);
            if (tx[0] !== 1'b1) ok = 1'b0;
            if (rst_epoch == ep) begin
                if (ok) rx_q.push_back(b);
                else frame_err++;
            end
        end
    end

    task automatic send_byte(input int i, input logic [7:0] d, input logic last, output int waited);
        s_valid[i] = 1'b1;
        s_data[i]  = d;
        s_tlast[i] = last;
        waited     = 0;
        forever begin
            @(negedge clk);
            if (s_ready[i] === 1'b1) break;
            waited++;
            if (waited > 200) begin
                n_tests++;
                n_fail++;
                $error("FAIL hs_timeout dut%0d: waited %0d cycles, required <= 200", i, waited);
                break;
            end
        end
        if (waited <= 200) n_sent[i]++;
        @(posedge clk);
        #1;
        s_valid[i] = 1'b0;
        s_data[i]  = 8'($urandom);
        s_tlast[i] = 1'($urandom);
    endtask

    task automatic send_frame(input int i, input int len, input bit gaps);
        int w;
        logic [7:0] d;
        if (i == 0) begin
            exp_q.push_back(8'hA5);
            exp_fb0.push_back(len);
        end
        for (int b = 0; b < len; b++) begin
            d = 8'($urandom);
            if (i == 0) exp_q.push_back(d);
            send_byte(i, d, (b == len - 1), w);
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                    s_data[i] = 8'($urandom);
                end
            end
        end
    endtask

    task automatic wait_fd(input int i, input int target);
        int c;
        c = 0;
        while (fd_cnt[i] < target && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check($sformatf("fd_count_dut%0d", i), fd_cnt[i], target);
    endtask

    task automatic timing_check(input int i, input int div, input int stops, input logic [7:0] d);
        int last_k;
        int tx_err;
        int first_bad;
        last_k    = (9 + stops) * div;
        tx_err    = 0;
        first_bad = -1;
        for (int k = 0; k <= last_k; k++) begin
            @(negedge clk);
            if (tx[i] !== exp_tx(k, div, d)) begin
                tx_err++;
                if (first_bad < 0) first_bad = k;
            end
            if (k == last_k - 1) begin
                check($sformatf("busy_before_done_dut%0d", i), busy[i], 1);
                check($sformatf("fd_early_dut%0d", i), frame_done[i], 0);
            end
            if (k == last_k) begin
                check($sformatf("busy_after_done_dut%0d", i), busy[i], 0);
                check($sformatf("fd_pulse_dut%0d", i), frame_done[i], 1);
            end
        end
        check($sformatf("tx_timing_dut%0d_first_bad_cycle_%0d", i, first_bad), tx_err, 0);
    endtask

    initial begin
        int w;
        int fd_before;
        int fd_target;
        logic [7:0] d1;
        reset   = 1'b1;
        s_valid = '0;
        s_tlast = '0;
        s_data  = '{8'h00, 8'h00};
        n_sent  = '{0, 0};
        fd_target = 0;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_tx", tx[0], 1);
        check("rst_s_ready", s_ready[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_frame_done", frame_done[0], 0);
        check("rst_frame_bytes", fb0, 0);
        check("rst_tx_dut1", tx[1], 1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ready_low_at_sof", s_ready[0], 0);
        @(posedge clk);
        #1;

        // Directed 4-byte frame
        exp_q.push_back(8'hA5);
        exp_fb0.push_back(4);
        for (int b = 1; b <= 4; b++) begin
            exp_q.push_back(8'(b));
            send_byte(0, 8'(b), (b == 4), w);
        end
        fd_target++;
        wait_fd(0, fd_target);
        check("frame_bytes_4", fb0, 4);
        repeat (3) @(posedge clk);
        #1;

        // Bit timing of 0x55 plus header backpressure
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h55);
        exp_fb0.push_back(1);
        send_byte(0, 8'h55, 1'b1, w);
        check("hdr_wait_dut0", w, (9 + STOP0) * DIV0 + 1);
        timing_check(0, DIV0, STOP0, 8'h55);
        check("frame_bytes_55", fb0, 1);
        fd_target++;

        // Back-to-back frames: 3 then 2, then random lengths
        send_frame(0, 3, 1'b1);
        send_frame(0, 2, 1'b1);
        for (int f = 0; f < 3; f++) send_frame(0, $urandom_range(1, 5), 1'b1);
        fd_target += 5;
        wait_fd(0, fd_target);

        // Reset in the middle of the second pixel's data bits
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h11);
        send_byte(0, 8'h11, 1'b0, w);
        send_byte(0, 8'h22, 1'b0, w);
        repeat (9) @(posedge clk);
        #1;
        reset     = 1'b1;
        fd_before = fd_cnt[0];
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_tx", tx[0], 1);
        check("midrst_busy", busy[0], 0);
        check("midrst_s_ready", s_ready[0], 0);
        check("midrst_frame_bytes", fb0, 0);
        check("midrst_frame_done", frame_done[0], 0);
        reset = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("midrst_no_frame_done", fd_cnt[0], fd_before);
        send_frame(0, 2, 1'b1);
        fd_target++;
        wait_fd(0, fd_target);
        check("frame_bytes_after_rst", fb0, 2);

        // Two stop bits, 1-byte frame, then counter saturation on a 2-bit counter
        @(posedge clk);
        #1;
        d1 = 8'($urandom);
        send_byte(1, d1, 1'b1, w);
        check("hdr_wait_dut1", w, (9 + STOP1) * DIV1 + 1);
        timing_check(1, DIV1, STOP1, d1);
        check("frame_bytes_1byte", fb1, 1);
        @(posedge clk);
        #1;
        send_frame(1, 5, 1'b0);
        wait_fd(1, 2);
        check("frame_bytes_saturated", fb1, 2'b11);

        repeat (60) @(negedge clk);
        check("rx_count", rx_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < rx_q.size(); j++)
            check($sformatf("rx_byte_%0d", j), rx_q[j], exp_q[j]);
        check("fb_count", fb_q0.size(), exp_fb0.size());
        for (int j = 0; j < exp_fb0.size() && j < fb_q0.size(); j++)
            check($sformatf("frame_bytes_log_%0d", j), fb_q0[j], exp_fb0[j]);
        check("fd_total_dut0", fd_cnt[0], fd_target);
        check("handshakes_dut0", hs_cnt[0], n_sent[0]);
        check("handshakes_dut1", hs_cnt[1], n_sent[1]);
        check("uart_framing_errors", frame_err, 0);
        check("ready_while_busy", viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
